wb_stage: RTL and testbench

Writeback stage of the 5-stage RISC-V pipeline, sitting between the MEM stage and the register file write port (`w_ena`/`w_addr`/`w_data`). It accepts one retiring instruction per handshake from MEM and, for loads, waits a variable number of cycles for data-memory read data. It aligns and sign- or zero-extends load data, suppresses illegal writes, and presents a registered one-cycle write pulse to the register file. It also maintains a retired-instruction counter.

---
 rtl/wb_stage_if.sv | 31 +++
 rtl/wb_stage.sv | 107 ++++++++++
 tb/tb_wb_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM-to-WB handshake, data-memory read return and register-file write port.
// master drives the MEM/dmem side, slave is the writeback stage.
interface wb_stage_if;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic        mem_w_ena_i;
  logic [4:0]  mem_w_addr_i;
  logic [31:0] mem_w_data_i;
  logic        mem_is_load_i;
  logic [2:0]  mem_funct3_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        w_ena_o;
  logic [4:0]  w_addr_o;
  logic [31:0] w_data_o;
  logic        retire_o;
  logic        load_err_o;
  logic [31:0] instret_o;

  modport master (
    output mem_valid_i, mem_w_ena_i, mem_w_addr_i, mem_w_data_i, mem_is_load_i,
           mem_funct3_i, dmem_rvalid_i, dmem_rdata_i,
    input  mem_ready_o, w_ena_o, w_addr_o, w_data_o, retire_o, load_err_o, instret_o
  );

  modport slave (
    input  mem_valid_i, mem_w_ena_i, mem_w_addr_i, mem_w_data_i, mem_is_load_i,
           mem_funct3_i, dmem_rvalid_i, dmem_rdata_i,
    output mem_ready_o, w_ena_o, w_addr_o, w_data_o, retire_o, load_err_o, instret_o
  );
endinterface

// File: rtl/wb_stage.sv
// RISC-V writeback stage: retires one instruction per MEM handshake, waits for
// load data, aligns/extends it and issues a registered register-file write pulse.
module wb_stage (
  input  logic      clk_100MHz,
  input  logic      rst,
  wb_stage_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  typedef enum logic {IDLE = 1'b0, LOAD_WAIT = 1'b1} state_t;

  state_t          state;
  logic [RW-1:0]   ld_addr;
  logic            ld_ena;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_off;
  logic [XLEN-1:0] ld_value;
  logic            ld_err;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic            xfer;

  assign xfer = bus.mem_valid_i & bus.mem_ready_o;

  // Select, extend and validate the load value from the returned word.
  always_comb begin
    ld_value = '0;
    ld_err   = 1'b0;
    byte_sel = 8'(bus.dmem_rdata_i >> {ld_off, 3'b000});
    half_sel = ld_off[1] ? bus.dmem_rdata_i[31:16] : bus.dmem_rdata_i[15:0];
    case (ld_funct3)
      3'b000: ld_value = {{24{byte_sel[7]}}, byte_sel};
      3'b001: begin
        ld_value = {{16{half_sel[15]}}, half_sel};
        ld_err   = ld_off[0];
      end
      3'b010: begin
        ld_value = bus.dmem_rdata_i;
        ld_err   = |ld_off;
      end
      3'b100: ld_value = {24'h0, byte_sel};
      3'b101: begin
        ld_value = {16'h0, half_sel};
        ld_err   = ld_off[0];
      end
      default: ld_err = 1'b1;
    endcase
  end

  // Control FSM, captured load context and all registered outputs.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state          <= IDLE;
      bus.mem_ready_o <= 1'b1;
      bus.w_ena_o    <= 1'b0;
      bus.w_addr_o   <= '0;
      bus.w_data_o   <= '0;
      bus.retire_o   <= 1'b0;
      bus.load_err_o <= 1'b0;
      bus.instret_o  <= '0;
      ld_addr        <= '0;
      ld_ena         <= 1'b0;
      ld_funct3      <= '0;
      ld_off         <= '0;
    end else begin
      bus.w_ena_o    <= 1'b0;
      bus.retire_o   <= 1'b0;
      bus.load_err_o <= 1'b0;
      bus.instret_o  <= bus.instret_o + XLEN'(bus.retire_o);
      case (state)
        IDLE: begin
          if (xfer) begin
            if (bus.mem_is_load_i) begin
              ld_addr         <= bus.mem_w_addr_i;
              ld_ena          <= bus.mem_w_ena_i;
              ld_funct3       <= bus.mem_funct3_i;
              ld_off          <= bus.mem_w_data_i[1:0];
              bus.mem_ready_o <= 1'b0;
              state           <= LOAD_WAIT;
            end else begin
              bus.retire_o <= 1'b1;
              bus.w_ena_o  <= bus.mem_w_ena_i && (bus.mem_w_addr_i != RW'(0));
              bus.w_addr_o <= bus.mem_w_addr_i;
              bus.w_data_o <= bus.mem_w_data_i;
            end
          end
        end
        LOAD_WAIT: begin
          if (bus.dmem_rvalid_i) begin
            bus.retire_o    <= 1'b1;
            bus.load_err_o  <= ld_err;
            bus.w_ena_o     <= ld_ena && (ld_addr != RW'(0)) && !ld_err;
            bus.w_addr_o    <= ld_addr;
            bus.w_data_o    <= ld_value;
            bus.mem_ready_o <= 1'b1;
            state           <= IDLE;
          end
        end
        default: begin
          bus.mem_ready_o <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage with hand-computed expectations.
module tb_wb_stage;
  logic clk_100MHz = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_ret = '0;

  always #5 clk_100MHz = ~clk_100MHz;

  wb_stage_if bus ();
  wb_stage dut (.clk_100MHz(clk_100MHz), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic quiet_cycle(input string tag);
    check({tag, "_retire"}, 32'(bus.retire_o), 32'd0);
    check({tag, "_wena"},   32'(bus.w_ena_o),  32'd0);
    check({tag, "_err"},    32'(bus.load_err_o), 32'd0);
  endtask

  // Non-load transfer; checks the retire cycle that follows.
  task automatic issue_alu(input logic [4:0] rd, input logic [31:0] data, input logic exp_wena);
    bus.mem_valid_i   = 1'b1;
    bus.mem_is_load_i = 1'b0;
    bus.mem_funct3_i  = 3'b111;
    bus.mem_w_ena_i   = 1'b1;
    bus.mem_w_addr_i  = rd;
    bus.mem_w_data_i  = data;
    tick();
    bus.mem_valid_i = 1'b0;
    check("alu_retire", 32'(bus.retire_o), 32'd1);
    check("alu_wena",   32'(bus.w_ena_o),  32'(exp_wena));
    check("alu_waddr",  32'(bus.w_addr_o), 32'(rd));
    check("alu_wdata",  bus.w_data_o,      data);
    check("alu_err",    32'(bus.load_err_o), 32'd0);
    check("alu_ready",  32'(bus.mem_ready_o), 32'd1);
    check("alu_instret", bus.instret_o,    exp_ret);
    exp_ret = exp_ret + 32'd1;
  endtask

  // Load transfer, wcyc cycles of wait (rvalid in the last one), then retire checks.
  task automatic run_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] baddr,
                          input int wcyc, input logic [31:0] rdata,
                          input logic exp_wena, input logic exp_err, input logic [31:0] exp_data);
    bus.mem_valid_i   = 1'b1;
    bus.mem_is_load_i = 1'b1;
    bus.mem_funct3_i  = f3;
    bus.mem_w_ena_i   = 1'b1;
    bus.mem_w_addr_i  = rd;
    bus.mem_w_data_i  = baddr;
    tick();
    bus.mem_valid_i = 1'b0;
    for (int i = 0; i < wcyc; i++) begin
      check("ld_wait_ready", 32'(bus.mem_ready_o), 32'd0);
      quiet_cycle("ld_wait");
      bus.dmem_rvalid_i = (i == wcyc - 1);
      bus.dmem_rdata_i  = (i == wcyc - 1) ? rdata : 32'hDEAD_BEEF;
      tick();
    end
    bus.dmem_rvalid_i = 1'b0;
    bus.dmem_rdata_i  = 32'h5A5A_5A5A;
    check("ld_retire",  32'(bus.retire_o),   32'd1);
    check("ld_err",     32'(bus.load_err_o), 32'(exp_err));
    check("ld_wena",    32'(bus.w_ena_o),    32'(exp_wena));
    check("ld_waddr",   32'(bus.w_addr_o),   32'(rd));
    if (!exp_err) check("ld_wdata", bus.w_data_o, exp_data);
    check("ld_ready",   32'(bus.mem_ready_o), 32'd1);
    check("ld_instret", bus.instret_o,       exp_ret);
    exp_ret = exp_ret + 32'd1;
  endtask

  initial begin
    rst                = 1'b1;
    bus.mem_valid_i    = 1'b0;
    bus.mem_w_ena_i    = 1'b0;
    bus.mem_w_addr_i   = '0;
    bus.mem_w_data_i   = '0;
    bus.mem_is_load_i  = 1'b0;
    bus.mem_funct3_i   = '0;
    bus.dmem_rvalid_i  = 1'b0;
    bus.dmem_rdata_i   = '0;
    tick();
    tick();
    quiet_cycle("rst");
    check("rst_ready",   32'(bus.mem_ready_o), 32'd1);
    check("rst_instret", bus.instret_o, 32'd0);
    check("rst_waddr",   32'(bus.w_addr_o), 32'd0);
    check("rst_wdata",   bus.w_data_o, 32'd0);
    rst = 1'b0;

    // Back-to-back non-loads, the x0 write suppressed.
    issue_alu(5'd1, 32'h11, 1'b1);
    issue_alu(5'd2, 32'h22, 1'b1);
    issue_alu(5'd0, 32'h33, 1'b0);
    tick();
    quiet_cycle("after_alu");
    check("instret_3", bus.instret_o, 32'd3);
    check("hold_wdata", bus.w_data_o, 32'h33);

    run_load(5'd5,  3'b000, 32'h1003, 3, 32'h80AB_CDEF, 1'b1, 1'b0, 32'hFFFF_FF80);
    run_load(5'd6,  3'b100, 32'h1003, 1, 32'h80AB_CDEF, 1'b1, 1'b0, 32'h0000_0080);
    run_load(5'd7,  3'b000, 32'h1001, 1, 32'h80AB_CDEF, 1'b1, 1'b0, 32'hFFFF_FFCD);
    run_load(5'd8,  3'b001, 32'h2002, 2, 32'h8001_1234, 1'b1, 1'b0, 32'hFFFF_8001);
    run_load(5'd9,  3'b101, 32'h2000, 1, 32'h8001_1234, 1'b1, 1'b0, 32'h0000_1234);
    run_load(5'd10, 3'b010, 32'h3000, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D);
    run_load(5'd0,  3'b010, 32'h3004, 1, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678);
    run_load(5'd11, 3'b010, 32'h3002, 1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0);
    run_load(5'd12, 3'b011, 32'h3000, 2, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0);
    run_load(5'd13, 3'b101, 32'h2001, 1, 32'h8001_1234, 1'b0, 1'b1, 32'h0);
    tick();
    quiet_cycle("after_ld");
    check("instret_13", bus.instret_o, 32'd13);

    // Spurious rvalid while idle.
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'hFFFF_FFFF;
    tick();
    bus.dmem_rvalid_i = 1'b0;
    tick();
    quiet_cycle("spur");
    check("spur_waddr",   32'(bus.w_addr_o), 32'd13);
    check("spur_instret", bus.instret_o, 32'd13);
    check("spur_ready",   32'(bus.mem_ready_o), 32'd1);

    // Reset while waiting for load data abandons the load.
    bus.mem_valid_i   = 1'b1;
    bus.mem_is_load_i = 1'b1;
    bus.mem_funct3_i  = 3'b010;
    bus.mem_w_addr_i  = 5'd14;
    bus.mem_w_data_i  = 32'h4000;
    tick();
    bus.mem_valid_i = 1'b0;
    check("rw_wait_ready", 32'(bus.mem_ready_o), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_ready",   32'(bus.mem_ready_o), 32'd1);
    check("rw_instret", bus.instret_o, 32'd0);
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'h7777_7777;
    tick();
    bus.dmem_rvalid_i = 1'b0;
    quiet_cycle("rw_after");
    check("rw_ready2",   32'(bus.mem_ready_o), 32'd1);
    check("rw_wdata",    bus.w_data_o, 32'd0);
    tick();
    quiet_cycle("rw_after2");
    check("rw_instret2", bus.instret_o, 32'd0);

    // Counter wrap from a preset value.
    force bus.instret_o = 32'hFFFF_FFFE;
    tick();
    release bus.instret_o;
    exp_ret = 32'hFFFF_FFFE;
    issue_alu(5'd3, 32'hA5A5_0001, 1'b1);
    issue_alu(5'd4, 32'hA5A5_0002, 1'b1);
    tick();
    check("wrap_instret", bus.instret_o, 32'd0);
    quiet_cycle("wrap_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
